// File: rtl/fifo_pkg.sv
// Shared types and helpers for the stream FIFO: read-mode selector and the
// pointer-advance function used for non-power-of-two depths.
package fifo_pkg;

  typedef enum logic {
    FIFO_FWFT = 1'b0,  // head word presented combinationally
    FIFO_STD  = 1'b1   // head word registered one cycle after a read request
  } fifo_mode_t;

  // Advance a pointer by one, wrapping from depth-1 back to 0.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage for the stream FIFO: one synchronous write port, one
// combinational read port, contents never reset.
module fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  // NOTE: no reset on the array; occupancy lives in the pointers and count,
  // so resetting every entry would only add reset fan-out for no benefit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with first-word-fall-through or registered-read
// output, occupancy count, level flags and sticky overflow/underflow flags.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter fifo_mode_t  MODE     = FIFO_FWFT,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       clear_in,
  input  logic                       s_valid_in,
  input  logic [WIDTH-1:0]           s_data_in,
  output logic                       s_ready_out,
  output logic                       m_valid_out,
  output logic [WIDTH-1:0]           m_data_out,
  input  logic                       m_ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       almost_full_out,
  output logic                       almost_empty_out,
  output logic                       overflow_out,
  output logic                       underflow_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Reject illegal parameter sets while elaborating.
  if (WIDTH < 1) begin : g_chk_width
    $error("stream_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("stream_fifo: DEPTH must be >= 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_chk_levels
    $error("stream_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic             is_full, not_empty;
  logic             unf_set;
  logic [WIDTH-1:0] rd_data;

  // Flow control depends only on the count register, never on m_ready_in,
  // so a write to a full FIFO is dropped even when a read happens alongside.
  assign is_full     = (count_q == DEPTH_C);
  assign not_empty   = (count_q != '0);
  assign s_ready_out = !is_full;
  assign push        = s_valid_in && s_ready_out;
  assign unf_set     = (MODE == FIFO_STD) && m_ready_in && !not_empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (push && !clear_in),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign pop         = not_empty && m_ready_in;
    assign m_valid_out = not_empty;
    // Gate the head word so stale array contents never leak out while empty
    // (and so the output is zero throughout reset).
    assign m_data_out  = not_empty ? rd_data : '0;
  end else begin : g_std
    logic             mv_q, mv_d;
    logic [WIDTH-1:0] md_q, md_d;

    assign pop = m_ready_in && not_empty;

    // Capture the popped word; valid pulses for the single following cycle.
    always_comb begin
      mv_d = pop && !clear_in;
      md_d = md_q;
      if (pop && !clear_in) begin
        md_d = rd_data;
      end
    end

    // Registered read-port output stage.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        mv_q <= 1'b0;
        md_q <= '0;
      end else begin
        mv_q <= mv_d;
        md_q <= md_d;
      end
    end

    assign m_valid_out = mv_q;
    assign m_data_out  = md_q;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), DEPTH));
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (s_valid_in && is_full) begin
        ovf_d = 1'b1;
      end
      if (unf_set) begin
        unf_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign count_out        = count_q;
  assign full_out         = is_full;
  assign empty_out        = !not_empty;
  assign almost_full_out  = (count_q >= AF_C);
  assign almost_empty_out = (count_q <= AE_C);
  assign overflow_out     = ovf_q;
  assign underflow_out    = unf_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: three instances (FWFT depth 5, STD depth 4,
// FWFT depth 8 with custom levels) share one stimulus bus; each scenario
// resets all of them and checks the instance it targets.
module tb_stream_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, clear, s_valid, m_ready;
  logic [7:0] s_data;

  always #5 clk = ~clk;

  logic       a_s_ready, a_m_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [7:0] a_m_data;
  logic [2:0] a_count;
  logic       b_s_ready, b_m_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [7:0] b_m_data;
  logic [2:0] b_count;
  logic       c_s_ready, c_m_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [7:0] c_m_data;
  logic [3:0] c_count;

  stream_fifo #(.WIDTH(8), .DEPTH(5), .MODE(FIFO_FWFT)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear),
    .s_valid_in(s_valid), .s_data_in(s_data), .s_ready_out(a_s_ready),
    .m_valid_out(a_m_valid), .m_data_out(a_m_data), .m_ready_in(m_ready),
    .count_out(a_count), .full_out(a_full), .empty_out(a_empty),
    .almost_full_out(a_af), .almost_empty_out(a_ae),
    .overflow_out(a_ovf), .underflow_out(a_unf));

  stream_fifo #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_STD)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear),
    .s_valid_in(s_valid), .s_data_in(s_data), .s_ready_out(b_s_ready),
    .m_valid_out(b_m_valid), .m_data_out(b_m_data), .m_ready_in(m_ready),
    .count_out(b_count), .full_out(b_full), .empty_out(b_empty),
    .almost_full_out(b_af), .almost_empty_out(b_ae),
    .overflow_out(b_ovf), .underflow_out(b_unf));

  stream_fifo #(.WIDTH(8), .DEPTH(8), .MODE(FIFO_FWFT), .AF_LEVEL(6), .AE_LEVEL(2)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear),
    .s_valid_in(s_valid), .s_data_in(s_data), .s_ready_out(c_s_ready),
    .m_valid_out(c_m_valid), .m_data_out(c_m_data), .m_ready_in(m_ready),
    .count_out(c_count), .full_out(c_full), .empty_out(c_empty),
    .almost_full_out(c_af), .almost_empty_out(c_ae),
    .overflow_out(c_ovf), .underflow_out(c_unf));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus starting at a falling edge; returns at the
  // next falling edge with inputs idle and outputs settled.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic clr);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    clear   = clr;
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    clear   = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    #2;
    // Reset values, observed before any clock edge.
    check("rst_count",   32'(a_count),   0);
    check("rst_empty",   32'(a_empty),   1);
    check("rst_ae",      32'(a_ae),      1);
    check("rst_full",    32'(a_full),    0);
    check("rst_s_ready", 32'(a_s_ready), 1);
    check("rst_m_valid", 32'(a_m_valid), 0);
    check("rst_m_data",  32'(a_m_data),  0);
    check("rst_ovf",     32'(a_ovf),     0);
    check("rst_unf",     32'(a_unf),     0);
    check("rst_std_valid", 32'(b_m_valid), 0);
    check("rst_std_data",  32'(b_m_data),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill depth-5 FWFT, overflow attempt, drain in order.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    check("fill_count",   32'(a_count),   5);
    check("fill_full",    32'(a_full),    1);
    check("fill_s_ready", 32'(a_s_ready), 0);
    check("fill_af",      32'(a_af),      1);
    check("fill_ovf0",    32'(a_ovf),     0);
    cyc(1'b1, 8'h16, 1'b0, 1'b0);
    check("ovf_set",   32'(a_ovf),    1);
    check("ovf_count", 32'(a_count),  5);
    for (int i = 0; i < 5; i++) begin
      check("drain_valid", 32'(a_m_valid), 1);
      check("drain_data",  32'(a_m_data),  32'(8'h11 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty",  32'(a_empty), 1);
    check("drain_valid0", 32'(a_m_valid), 0);
    check("ovf_sticky",   32'(a_ovf),   1);

    // Full FIFO with simultaneous write and read: write dropped, read taken.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("fullrw_count", 32'(a_count), 4);
    check("fullrw_ovf",   32'(a_ovf),   1);
    for (int i = 0; i < 4; i++) begin
      check("fullrw_data", 32'(a_m_data), 32'(8'h12 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("fullrw_empty", 32'(a_empty), 1);

    // 12 pushes and 12 pops through depth 5: both pointers wrap twice.
    do_reset();
    begin
      int k;
      k = 0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 3; i < 12; i++) begin
        check("wrap_data", 32'(a_m_data), 32'(8'h30 + k));
        cyc(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
        k++;
        check("wrap_count", 32'(a_count), 3);
      end
      for (int i = 0; i < 3; i++) begin
        check("wrap_tail", 32'(a_m_data), 32'(8'h30 + k));
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        k++;
      end
    end
    check("wrap_empty", 32'(a_empty), 1);
    check("wrap_ovf",   32'(a_ovf),   0);

    // Registered-read mode: read on empty sets underflow, data one cycle later.
    do_reset();
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    check("std_unf",       32'(b_unf),     1);
    check("std_count1",    32'(b_count),   1);
    check("std_valid0",    32'(b_m_valid), 0);
    check("fwft_no_unf",   32'(a_unf),     0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("std_valid1",    32'(b_m_valid), 1);
    check("std_data",      32'(b_m_data),  8'hA5);
    check("std_count0",    32'(b_count),   0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("std_pulse_end", 32'(b_m_valid), 0);
    check("std_hold",      32'(b_m_data),  8'hA5);
    check("std_unf_stky",  32'(b_unf),     1);
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("std_b2b_v1", 32'(b_m_valid), 1);
    check("std_b2b_d1", 32'(b_m_data),  8'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("std_b2b_v2", 32'(b_m_valid), 1);
    check("std_b2b_d2", 32'(b_m_data),  8'h02);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("std_b2b_v3", 32'(b_m_valid), 0);
    check("std_b2b_d3", 32'(b_m_data),  8'h02);
    check("std_b2b_cnt", 32'(b_count),  1);

    // Threshold flags on depth 8 with AF=6, AE=2.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      check("lvl_af", 32'(c_af), (i >= 6) ? 1 : 0);
      check("lvl_ae", 32'(c_ae), (i <= 2) ? 1 : 0);
    end
    check("lvl_full",    32'(c_full),    1);
    check("lvl_s_ready", 32'(c_s_ready), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("lvl_count7",  32'(c_count),   7);
    check("lvl_full0",   32'(c_full),    0);
    check("lvl_af7",     32'(c_af),      1);

    // Clear beats push and pop, zeroes count and sticky flags.
    do_reset();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_pre_unf", 32'(b_unf), 1);
    cyc(1'b1, 8'h21, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h23, 1'b0, 1'b0);
    check("clr_pre_cnt", 32'(c_count), 3);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    check("clr_count",   32'(c_count),   0);
    check("clr_empty",   32'(c_empty),   1);
    check("clr_ae",      32'(c_ae),      1);
    check("clr_s_ready", 32'(c_s_ready), 1);
    check("clr_std_cnt", 32'(b_count),   0);
    check("clr_std_unf", 32'(b_unf),     0);
    check("clr_std_val", 32'(b_m_valid), 0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b1, 8'h6B, 1'b0, 1'b0);
    check("clr_head",    32'(c_m_data),  8'h5A);
    check("clr_cnt2",    32'(c_count),   2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_std_d",   32'(b_m_data),  8'h5A);
    check("clr_next",    32'(c_m_data),  8'h6B);

    // Asynchronous reset mid-burst, observed before the next clock edge.
    s_valid = 1'b1;
    s_data  = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",   32'(c_count),   0);
    check("arst_empty",   32'(c_empty),   1);
    check("arst_ae",      32'(c_ae),      1);
    check("arst_full",    32'(c_full),    0);
    check("arst_s_ready", 32'(c_s_ready), 1);
    check("arst_valid",   32'(c_m_valid), 0);
    check("arst_data",    32'(c_m_data),  0);
    check("arst_std_d",   32'(b_m_data),  0);
    check("arst_std_v",   32'(b_m_valid), 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    check("post_rst_data",  32'(c_m_data), 8'hC3);
    check("post_rst_count", 32'(c_count),  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 8: entry count, any integer >=2, not restricted to powers of two.
REQ-003 Parameter MODE, default FIFO_FWFT: FIFO_FWFT (first-word-fall-through) or FIFO_STD (registered read).
REQ-004 Parameter AF_LEVEL, default DEPTH-1: almost-full threshold.
REQ-005 Parameter AE_LEVEL, default 1: almost-empty threshold.
REQ-006 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n_in  input  1  asynchronous, active-low reset.
REQ-008 clear_in  input  1  synchronous flush.
REQ-009 s_valid_in  input  1  write request.
REQ-010 s_data_in  input  WIDTH  write data.
REQ-011 s_ready_out  output  1  FIFO can accept a write.
REQ-012 m_valid_out  output  1  m_data_out holds a valid word.
REQ-013 m_data_out  output  WIDTH  read data.
REQ-014 m_ready_in  input  1  consumer accept (FWFT) / read request (STD).
REQ-015 count_out  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-016 full_out, empty_out, almost_full_out, almost_empty_out  output  1 each  level flags.
REQ-017 overflow_out, underflow_out  output  1 each  sticky error flags.

Function
REQ-018 s_ready_out SHALL equal (count == DEPTH) negated, derived from the count register only; a write is push = s_valid_in && s_ready_out.
REQ-019 A write to a full FIFO SHALL be dropped; it SHALL also drop when a read occurs in the same cycle; s_valid_in while full SHALL set overflow_out.
REQ-020 Write and read pointers SHALL advance by one and wrap from DEPTH-1 to 0.
REQ-021 FIFO_FWFT: m_valid_out = (count != 0); m_data_out = the head entry combinationally; pop = m_valid_out && m_ready_in; underflow_out never set.
REQ-022 FIFO_STD: pop = m_ready_in && (count != 0). The popped word SHALL appear on m_data_out one cycle later, with m_valid_out high for exactly that cycle. m_data_out SHALL hold its value otherwise.
REQ-023 FIFO_STD: m_ready_in while count == 0 SHALL be ignored and SHALL set underflow_out, even if a push occurs in the same cycle.
REQ-024 count: push only +1; pop only -1; push and pop together unchanged.
REQ-025 full_out = (count == DEPTH), empty_out = (count == 0), almost_full_out = (count >= AF_LEVEL), almost_empty_out = (count <= AE_LEVEL), all taken from the count register. Each flag SHALL therefore change in the cycle after the causing push or pop.
REQ-026 Push and pop in the same cycle SHALL be independent, including when the pointers are equal; data SHALL never be reordered, duplicated or lost.
REQ-027 clear_in SHALL take priority over push and pop in the same cycle, and both are discarded. It SHALL zero the pointers, count, m_valid_out, overflow_out and underflow_out. Memory contents SHALL be left unchanged.
REQ-028 Sticky flags SHALL clear only on clear_in or reset.

Reset
REQ-029 While rst_n_in is low, the following SHALL hold independent of clk_in: pointers = 0, count_out = 0, m_valid_out = 0, m_data_out = 0, overflow_out = 0, underflow_out = 0, empty_out = 1, almost_empty_out = 1, full_out = 0, s_ready_out = 1.
REQ-030 The storage array SHALL NOT be reset.
REQ-031 Reset asserted mid-transfer SHALL discard all contents; the first push after reset release SHALL be stored at entry 0.

Structure
REQ-032 Package fifo_pkg SHALL hold the fifo_mode_t enum (FIFO_FWFT, FIFO_STD) and a ptr-wrap helper function.
REQ-033 Storage SHALL be a sub-module fifo_ram: WIDTH x DEPTH, one synchronous write port and one combinational read port, no reset.
REQ-034 Parameter checks (DEPTH >= 2, AE_LEVEL < AF_LEVEL <= DEPTH) SHALL be elaboration-time assertions.

Verification
REQ-035 FWFT, DEPTH=5: push 0x11..0x15 -> full_out=1, s_ready_out=0; 6th write 0x16 dropped, overflow_out=1. Pops return 0x11..0x15 in order.
REQ-036 FWFT, DEPTH=5: 12 pushes interleaved with pops, 12 pops total -> pointers wrap 4->0 twice; output sequence equals input sequence.
REQ-037 FWFT, count=5: s_valid_in=1 and m_ready_in=1 in the same cycle -> write dropped, count=4, overflow_out=1.
REQ-038 STD: push 0xA5 into an empty FIFO and assert m_ready_in in the same cycle -> underflow_out=1. Next cycle m_ready_in -> the cycle after, m_data_out=0xA5 and m_valid_out pulses for 1 cycle.
REQ-039 DEPTH=8, AF_LEVEL=6, AE_LEVEL=2: almost_full_out rises in the cycle after the 6th push. almost_empty_out falls in the cycle after the 3rd push.
REQ-040 With count=3: clear_in together with a push -> count=0, empty_out=1, flags cleared. Separately, rst_n_in low mid-burst -> outputs equal REQ-029 values without waiting for a clock edge.
